// File: rtl/soc_system_clkgen_pkg.sv
// rtl/soc_system_clkgen_pkg.sv - shared types and divisor sanitising for the clock generator
package soc_system_clkgen_pkg;

  localparam int CLKGEN_CNT_W = 16;

  typedef enum logic [1:0] {
    ALIGN  = 2'd0,
    SETTLE = 2'd1,
    LOCKED = 2'd2
  } clkgen_state_e;

  typedef struct packed {
    logic [31:0] div;
    logic [31:0] high;
    logic [31:0] phase;
  } clkgen_cfg_t;

  // Worked at 32 bits; every clamped result is <= its input or 2, so it fits back into CNT_W.
  function automatic clkgen_cfg_t clkgen_sanitise(input logic [31:0] n,
                                                  input logic [31:0] h,
                                                  input logic [31:0] p);
    clkgen_cfg_t r;
    r.div   = n;
    r.high  = h;
    r.phase = p;
    if (n == 32'd0) begin
      r.high  = 32'd0;
      r.phase = 32'd0;
    end else begin
      if (n == 32'd1) r.div = 32'd2;
      if (h == 32'd0) r.high = 32'd1;
      else if (h >= r.div) r.high = r.div - 32'd1;
      if (p >= r.div) r.phase = r.div - 32'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/soc_system_clkgen_chan.sv
// rtl/soc_system_clkgen_chan.sv - one divided-clock channel: wrap counter plus registered clock and edge strobe
module soc_system_clkgen_chan
  import soc_system_clkgen_pkg::*;
#(
  parameter int CNT_W = CLKGEN_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             blank,
  input  logic             align,
  input  logic             locked,
  input  logic [CNT_W-1:0] div,
  input  logic [CNT_W-1:0] high,
  input  logic [CNT_W-1:0] phase,
  output logic             outclk,
  output logic             en
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_n;

  always_comb begin
    if (align) begin
      cnt_n = phase;
    end else if (cnt >= div - CNT_W'(1)) begin
      cnt_n = '0;
    end else begin
      cnt_n = cnt + CNT_W'(1);
    end
  end

  // Outputs are computed from cnt_n so they always describe the cnt value they sit next to.
  always_ff @(posedge clk) begin
    if (rst || blank || (div == '0)) begin
      cnt    <= (div == '0) ? '0 : phase;
      outclk <= 1'b0;
      en     <= 1'b0;
    end else begin
      cnt    <= cnt_n;
      outclk <= (cnt_n < high);
      en     <= (cnt_n == '0) && locked;
    end
  end

endmodule

// File: rtl/soc_system_clkgen_div.sv
// rtl/soc_system_clkgen_div.sv - multi-channel integer clock divider with align/settle/lock sequencing
module soc_system_clkgen_div
  import soc_system_clkgen_pkg::*;
#(
  parameter int                          NUM_CLOCKS  = 3,
  parameter int                          CNT_W       = CLKGEN_CNT_W,
  parameter logic [NUM_CLOCKS*CNT_W-1:0] DIV_INIT    = {16'd4, 16'd5, 16'd2},
  parameter logic [NUM_CLOCKS*CNT_W-1:0] HIGH_INIT   = {16'd2, 16'd2, 16'd1},
  parameter logic [NUM_CLOCKS*CNT_W-1:0] PHASE_INIT  = {16'd0, 16'd0, 16'd0},
  parameter int                          LOCK_CYCLES = 256,
  localparam int                         SEL_W       = (NUM_CLOCKS > 1) ? $clog2(NUM_CLOCKS) : 1
) (
  input  logic                  refclk,
  input  logic                  rst,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [SEL_W-1:0]      cfg_sel,
  input  logic [CNT_W-1:0]      cfg_div,
  input  logic [CNT_W-1:0]      cfg_high,
  input  logic [CNT_W-1:0]      cfg_phase,
  output logic [NUM_CLOCKS-1:0] outclk,
  output logic [NUM_CLOCKS-1:0] outclk_en,
  output logic                  locked
);

  localparam int LCW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

  clkgen_state_e    state;
  clkgen_state_e    state_n;
  logic [LCW-1:0]   lock_cnt;
  logic [CNT_W-1:0] div_q   [NUM_CLOCKS];
  logic [CNT_W-1:0] high_q  [NUM_CLOCKS];
  logic [CNT_W-1:0] phase_q [NUM_CLOCKS];
  logic [CNT_W-1:0] init_div   [NUM_CLOCKS];
  logic [CNT_W-1:0] init_high  [NUM_CLOCKS];
  logic [CNT_W-1:0] init_phase [NUM_CLOCKS];
  logic             sel_ok;
  logic             realign;
  clkgen_cfg_t      cfg_san;
  logic             unused_cfg_san;

  assign sel_ok         = 32'(cfg_sel) < 32'(NUM_CLOCKS);
  assign realign        = cfg_valid && cfg_ready && sel_ok;
  assign cfg_san        = clkgen_sanitise(32'(cfg_div), 32'(cfg_high), 32'(cfg_phase));
  assign unused_cfg_san = ^cfg_san;

  always_comb begin
    state_n = state;
    case (state)
      ALIGN:   state_n = SETTLE;
      SETTLE:  if (lock_cnt == LCW'(LOCK_CYCLES - 1)) state_n = LOCKED;
      LOCKED:  if (realign) state_n = ALIGN;
      default: state_n = ALIGN;
    endcase
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      state     <= ALIGN;
      lock_cnt  <= '0;
      locked    <= 1'b0;
      cfg_ready <= 1'b0;
      for (int i = 0; i < NUM_CLOCKS; i++) begin
        div_q[i]   <= init_div[i];
        high_q[i]  <= init_high[i];
        phase_q[i] <= init_phase[i];
      end
    end else begin
      state     <= state_n;
      locked    <= (state_n == LOCKED);
      cfg_ready <= (state_n == LOCKED);
      lock_cnt  <= (state == SETTLE) ? lock_cnt + LCW'(1) : '0;
      for (int i = 0; i < NUM_CLOCKS; i++) begin
        if (realign && (cfg_sel == SEL_W'(i))) begin
          div_q[i]   <= cfg_san.div[CNT_W-1:0];
          high_q[i]  <= cfg_san.high[CNT_W-1:0];
          phase_q[i] <= cfg_san.phase[CNT_W-1:0];
        end
      end
    end
  end

  // A realign blanks every channel, not only the one being reprogrammed.
  for (genvar g = 0; g < NUM_CLOCKS; g++) begin : g_chan
    clkgen_cfg_t init_san;
    logic        unused_init_san;

    assign init_san        = clkgen_sanitise(32'(DIV_INIT[g*CNT_W +: CNT_W]),
                                             32'(HIGH_INIT[g*CNT_W +: CNT_W]),
                                             32'(PHASE_INIT[g*CNT_W +: CNT_W]));
    assign unused_init_san = ^init_san;
    assign init_div[g]     = init_san.div[CNT_W-1:0];
    assign init_high[g]    = init_san.high[CNT_W-1:0];
    assign init_phase[g]   = init_san.phase[CNT_W-1:0];

    soc_system_clkgen_chan #(
      .CNT_W (CNT_W)
    ) u_chan (
      .clk    (refclk),
      .rst    (rst),
      .blank  (realign),
      .align  (state == ALIGN),
      .locked (state_n == LOCKED),
      .div    (div_q[g]),
      .high   (high_q[g]),
      .phase  (phase_q[g]),
      .outclk (outclk[g]),
      .en     (outclk_en[g])
    );
  end

endmodule
